// File: rtl/cp_insert_block_pkg.sv
// Shared defaults and read-FSM state type for the cyclic-prefix inserter.
package cp_insert_block_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_NFFT   = 64;
    localparam int unsigned DEF_NCP    = 16;
    localparam int unsigned SYM_LEN    = DEF_NFFT + DEF_NCP;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCp   = 2'd1,
        StData = 2'd2
    } rd_state_e;

endpackage

// File: rtl/cp_insert_block_ram.sv
// Dual-bank sample store, four DATA_W lanes packed per word; one write port, one async read port.
module cp_insert_block_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4*DATA_W-1:0]   wr_data,
    input  logic                  rd_bank,
    input  logic [AW-1:0]         rd_addr,
    output logic [4*DATA_W-1:0]   rd_data
);

    logic [4*DATA_W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/cp_insert_block.sv
// Ping-pong cyclic-prefix inserter for two TX streams: captures NFFT samples per bank and
// replays the last NCP samples followed by the full symbol.
module cp_insert_block
    import cp_insert_block_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NFFT   = DEF_NFFT,
    parameter int unsigned NCP    = DEF_NCP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1_re,
    input  logic [DATA_W-1:0] in1_im,
    input  logic [DATA_W-1:0] in2_re,
    input  logic [DATA_W-1:0] in2_im,
    output logic              out_valid,
    output logic              symbol_start,
    output logic              symbol_end,
    output logic [DATA_W-1:0] out1_re,
    output logic [DATA_W-1:0] out1_im,
    output logic [DATA_W-1:0] out2_re,
    output logic [DATA_W-1:0] out2_im,
    output logic [7:0]        dbg_sym_cnt
);

    localparam int unsigned CNT_W = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFFT - 1);
    localparam logic [CNT_W-1:0] CP_FIRST = CNT_W'(NFFT - NCP);

    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             in_ready_q, in_ready_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    rd_state_e        state_q, state_d;
    logic [7:0]       sym_cnt_q, sym_cnt_d;

    logic             wr_fire, wr_last;
    logic             emit, first_cp, last_data;
    logic [4*DATA_W-1:0] rd_data;

    logic                out_valid_q, symbol_start_q, symbol_end_q;
    logic [4*DATA_W-1:0] out_data_q;

    assign wr_fire = in_valid && in_ready_q;
    assign wr_last = wr_fire && (wr_cnt_q == CNT_LAST);

    cp_insert_block_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NFFT),
        .AW     (CNT_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_cnt_q),
        .wr_data ({in1_re, in1_im, in2_re, in2_im}),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data)
    );

    // Write side; fill and release of the two banks are independent and may coincide.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        bank_full_d = bank_full_q;
        if (wr_fire) begin
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
        end
        if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (last_data) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        in_ready_d = !bank_full_d[wr_bank_d];
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        sym_cnt_d = sym_cnt_q;
        emit      = 1'b0;
        first_cp  = 1'b0;
        last_data = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = StCp;
                    rd_cnt_d = CP_FIRST;
                end
            end
            StCp: begin
                emit     = 1'b1;
                first_cp = (rd_cnt_q == CP_FIRST);
                if (rd_cnt_q == CNT_LAST) begin
                    state_d  = StData;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StData: begin
                emit = 1'b1;
                if (rd_cnt_q == CNT_LAST) begin
                    last_data = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    sym_cnt_d = sym_cnt_q + 8'd1;
                    // Chain straight into the next prefix when the other bank is waiting.
                    if (bank_full_q[~rd_bank_q]) begin
                        state_d  = StCp;
                        rd_cnt_d = CP_FIRST;
                    end else begin
                        state_d  = StIdle;
                        rd_cnt_d = '0;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                rd_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            bank_full_q <= 2'b00;
            in_ready_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            state_q     <= StIdle;
            sym_cnt_q   <= 8'd0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            bank_full_q <= bank_full_d;
            in_ready_q  <= in_ready_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            symbol_start_q <= 1'b0;
            symbol_end_q   <= 1'b0;
            out_data_q     <= '0;
        end else begin
            out_valid_q    <= emit;
            symbol_start_q <= first_cp;
            symbol_end_q   <= last_data;
            if (emit) begin
                out_data_q <= rd_data;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign symbol_start = symbol_start_q;
    assign symbol_end   = symbol_end_q;
    assign out1_re      = out_data_q[4*DATA_W-1 -: DATA_W];
    assign out1_im      = out_data_q[3*DATA_W-1 -: DATA_W];
    assign out2_re      = out_data_q[2*DATA_W-1 -: DATA_W];
    assign out2_im      = out_data_q[DATA_W-1 -: DATA_W];
    assign dbg_sym_cnt  = sym_cnt_q;

endmodule

// File: tb/tb_cp_insert_block.sv
// Randomised bench for cp_insert_block against a queue-based symbol/prefix reference model.
module tb_cp_insert_block;
    import cp_insert_block_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int NF = DEF_NFFT;
    localparam int NC = DEF_NCP;
    localparam int SL = SYM_LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in1_re = '0, in1_im = '0, in2_re = '0, in2_im = '0;
    logic          out_valid, symbol_start, symbol_end;
    logic [DW-1:0] out1_re, out1_im, out2_re, out2_im;
    logic [7:0]    dbg_sym_cnt;

    always #5 clk = ~clk;

    cp_insert_block dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in1_re       (in1_re),
        .in1_im       (in1_im),
        .in2_re       (in2_re),
        .in2_im       (in2_im),
        .out_valid    (out_valid),
        .symbol_start (symbol_start),
        .symbol_end   (symbol_end),
        .out1_re      (out1_re),
        .out1_im      (out1_im),
        .out2_re      (out2_re),
        .out2_im      (out2_im),
        .dbg_sym_cnt  (dbg_sym_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each completed symbol expands to prefix + body in the expected queue.
    typedef struct {
        logic [63:0] data;
        bit          start;
        bit          fin;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] part [NF];
    int          part_n = 0;
    int          acc_tot = 0;
    int          last_full_edge = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          n_starts = 0;
    int          exp_sym = 0;
    int          last_start = 0;
    bit          have_start = 0;
    bit          lat_chk_en = 0;
    bit          gap_chk_en = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_n     = 0;
            acc_tot    = 0;
            exp_sym    = 0;
            have_start = 0;
        end else begin
            if (out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("data", {out1_re, out1_im, out2_re, out2_im}, mon_e.data);
                    check_val("flags", {symbol_start, symbol_end}, {mon_e.start, mon_e.fin});
                    if (mon_e.fin) begin
                        exp_sym++;
                        check_val("dbg_sym_cnt_at_end", dbg_sym_cnt, exp_sym % 256);
                    end
                end
                if (symbol_start) begin
                    n_starts++;
                    if (gap_chk_en && have_start) check_val("start_spacing", cyc - last_start, SL);
                    if (lat_chk_en) check_val("latency", cyc - last_full_edge, 2);
                    have_start = 1;
                    last_start = cyc;
                end
            end else begin
                check_val("flags_idle", {symbol_start, symbol_end}, 2'b00);
            end
            if (!gap_chk_en) have_start = 0;

            if (in_valid && in_ready) begin
                part[part_n] = {in1_re, in1_im, in2_re, in2_im};
                part_n++;
                acc_tot++;
                if (part_n == NF) begin
                    for (int i = 0; i < SL; i++) begin
                        exp_t e;
                        e.data  = (i < NC) ? part[NF - NC + i] : part[i - NC];
                        e.start = (i == 0);
                        e.fin   = (i == SL - 1);
                        exp_q.push_back(e);
                    end
                    part_n         = 0;
                    last_full_edge = cyc + 1;
                end
            end
        end
    end

    task automatic reset_now();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("reset_data", {out1_re, out1_im, out2_re, out2_im}, 64'd0);
        check_val("reset_ctrl", {out_valid, symbol_start, symbol_end, in_ready, dbg_sym_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("ready_after_reset", in_ready, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_now();
    endtask

    // vmode: 0 continuous, 1 alternating valid, 2 random valid. kpat selects the ramp pattern.
    task automatic send(input int nsym, input int vmode, input bit kpat);
        int  sent = 0;
        int  guard = 0;
        bit  tog = 1'b1;
        bit  acc;
        @(posedge clk);
        #1;
        while (sent < nsym * NF) begin
            int k = sent % NF;
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (kpat) begin
                in1_re = DW'(k);
                in1_im = DW'(-k);
                in2_re = DW'(1000 + k);
                in2_im = DW'(2000 + k);
            end else begin
                in1_re = DW'($urandom);
                in1_im = DW'($urandom);
                in2_re = DW'($urandom);
                in2_im = DW'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            guard++;
            if (guard > nsym * NF * 4 + 1000) begin
                check_val("send_timeout", sent, nsym * NF);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 2000) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (g >= 2000) check_val("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        #2;
    endtask

    // After n accepted samples both banks are full: in_ready must stay low until the release.
    task automatic full_watch(input int n);
        int g = 0;
        bit prev;
        while (acc_tot < n && g < 5000) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (g >= 5000) check_val("fill_timeout", acc_tot, n);
        @(negedge clk);
        #2;
        check_val("ready_low_both_full", in_ready, 0);
        prev = in_ready;
        g = 0;
        while (!symbol_end && g < 500) begin
            prev = in_ready;
            @(negedge clk);
            #2;
            g++;
        end
        check_val("release_seen", symbol_end, 1);
        check_val("ready_before_release", prev, 0);
        check_val("ready_at_release", in_ready, 1);
    endtask

    initial begin
        int base;
        int sbase;
        int g;

        do_reset();

        // Single symbol, ramp pattern, idle read side.
        base = out_cnt;
        lat_chk_en = 1'b1;
        send(1, 0, 1'b1);
        drain();
        lat_chk_en = 1'b0;
        check_val("single_out_count", out_cnt - base, SL);
        check_val("single_dbg", dbg_sym_cnt, 1);

        // Same symbol with alternating valid gaps.
        base = out_cnt;
        lat_chk_en = 1'b1;
        send(1, 1, 1'b1);
        drain();
        lat_chk_en = 1'b0;
        check_val("gaps_out_count", out_cnt - base, SL);
        check_val("gaps_dbg", dbg_sym_cnt, 2);

        // Three symbols back to back.
        do_reset();
        base  = out_cnt;
        sbase = n_starts;
        gap_chk_en = 1'b1;
        fork
            send(3, 0, 1'b0);
            full_watch(2 * NF);
        join
        drain();
        gap_chk_en = 1'b0;
        check_val("b2b_out_count", out_cnt - base, 3 * SL);
        check_val("b2b_starts", n_starts - sbase, 3);
        check_val("b2b_dbg", dbg_sym_cnt, 3);

        // Both banks full while the first symbol streams.
        do_reset();
        fork
            send(2, 0, 1'b0);
            full_watch(2 * NF);
        join
        drain();
        check_val("full_dbg", dbg_sym_cnt, 2);

        // Random valid pattern and random data.
        base = out_cnt;
        send(4, 2, 1'b0);
        drain();
        check_val("rand_out_count", out_cnt - base, 4 * SL);
        check_val("rand_dbg", dbg_sym_cnt, 6);

        // Reset in the middle of an output symbol.
        base = out_cnt;
        send(1, 0, 1'b0);
        g = 0;
        while (out_cnt - base < 30 && g < 500) begin
            @(negedge clk);
            #2;
            g++;
        end
        check_val("midstream_reached", out_cnt - base, 30);
        reset_now();
        base = out_cnt;
        lat_chk_en = 1'b1;
        send(1, 0, 1'b0);
        drain();
        lat_chk_en = 1'b0;
        check_val("post_reset_out_count", out_cnt - base, SL);
        check_val("post_reset_dbg", dbg_sym_cnt, 1);

        // 256 symbols wrap the debug counter.
        do_reset();
        base = out_cnt;
        send(256, 0, 1'b0);
        drain();
        check_val("wrap_out_count", out_cnt - base, 256 * SL);
        check_val("wrap_dbg", dbg_sym_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp_insert_block.md
Name: cp_insert_block

Overview:
- Transmit-side cyclic-prefix inserter for the 2x2 MIMO OFDM chain. It sits between the per-antenna IFFT outputs and the DAC/channel model.
- Accepts NFFT time-domain samples per symbol for two TX streams. It emits NCP+NFFT samples per symbol (CP = last NCP samples, then the full symbol) with a one-cycle symbol_start pulse.
- Double-buffered (ping-pong), so a new symbol can be captured while the previous one streams out. Consecutive symbols leave with no gap.

Parameters:
- DATA_W, 16, sample component width (signed)
- NFFT, 64, samples per OFDM symbol body
- NCP, 16, cyclic-prefix length; must satisfy 0 < NCP <= NFFT

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in1_re, in1_im  in  DATA_W each  TX stream 1 sample (signed)
- in2_re, in2_im  in  DATA_W each  TX stream 2 sample (signed)
- out_valid  out  1  output sample valid
- symbol_start  out  1  high with first CP sample of each symbol
- symbol_end  out  1  high with last data sample of each symbol
- out1_re, out1_im, out2_re, out2_im  out  DATA_W each  output samples (signed)
- dbg_sym_cnt  out  8  count of symbols fully emitted, wraps at 255->0

Behaviour:
- Reset (async, any state):
  - all outputs 0 and in_ready 0 while rst_n low; in_ready is 1 on the first cycle after release
  - both bank_full flags, counters, wr_bank/rd_bank and the FSM cleared
  - a partial symbol in flight is discarded; no output glitch
- Storage: two banks x 4 arrays x NFFT entries.
  - wr_bank, wr_cnt (0..NFFT-1); bank_full[1:0]; rd_bank, rd_cnt
- Write side:
  - a sample is accepted on an edge where in_valid && in_ready; it is stored at bank[wr_bank][wr_cnt] and wr_cnt increments
  - on accepting sample NFFT-1: set bank_full[wr_bank], toggle wr_bank, clear wr_cnt
  - in_ready = !bank_full[wr_bank], decoded from registers only (no combinational path from in_valid)
  - in_valid gaps allowed anywhere in a symbol; the partial count is held
- Read FSM: S_IDLE, S_CP, S_DATA.
  - S_IDLE: if bank_full[rd_bank], go to S_CP with rd_cnt = NFFT-NCP.
  - S_CP: emit bank[rd_bank][rd_cnt] (out_valid=1; symbol_start=1 on the first CP sample only). After rd_cnt = NFFT-1, go to S_DATA with rd_cnt = 0.
  - S_DATA: emit bank[rd_bank][rd_cnt]. On rd_cnt = NFFT-1:
    - assert symbol_end with that sample
    - clear bank_full[rd_bank], toggle rd_bank, increment dbg_sym_cnt
    - if the other bank is already full, go directly to S_CP with no idle cycle; else go to S_IDLE
  - Outputs are registered. out_valid, symbol_start and symbol_end are 0 in any cycle with no sample emitted; data outputs hold their last value.
- Latency: first CP sample is on the outputs in the cycle after the second rising edge following the edge that captured input sample NFFT-1, provided the read side is idle.
- Throughput: output is gapless while the input keeps one bank full ahead. The input is throttled to NFFT per NCP+NFFT cycles in steady state.
- Simultaneous events:
  - a release of rd_bank and a set of the other bank on the same edge are independent, and both take effect
  - a bank released on edge t is writable (in_ready=1) from cycle t+1
  - write and read never target the same bank
- No output backpressure; the downstream consumer must accept every out_valid sample.
- No arithmetic; sample values pass bit-exact. Counter widths are $clog2(NFFT).

Decomposition:
- Shared package/header (ofdm_params):
  - NFFT, NCP, DATA_W defaults
  - SYM_LEN = NFFT+NCP
  - state encodings as localparams (3'd0..), plain Verilog for Icarus compatibility
- One natural sub-module: cp_bank_ram, a dual-bank, 4-lane sample memory with 1 write port and 1 read port, instantiated once.

Test Plan:
- Single symbol: stream 1 re = k, im = -k; stream 2 re = 1000+k, im = 2000+k, for k = 0..63 → 80 out_valid cycles. Stream 1 re sequence is 48..63 then 0..63; symbol_start only on the value-48 sample, symbol_end only on the final 63; dbg_sym_cnt = 1.
- Back-to-back: in_valid held high for 3 symbols → in_ready deasserts after 128 accepted samples until the first release. 240 contiguous out_valid cycles with exactly 3 symbol_start pulses spaced 80 cycles apart; dbg_sym_cnt = 3.
- Input gaps: in_valid toggling 1,0,1,0 across one symbol → output content identical to the single-symbol case; latency measured from the last accepted sample matches the specified value.
- Both banks full: hold input for 2 symbols while the first streams → in_ready = 0 until the first symbol's symbol_end edge, then 1 on the next cycle.
- Reset mid-stream: assert rst_n low at output sample 30 → all outputs 0 immediately. After release, a fresh symbol produces a correct 80-sample output with no residue from the aborted data.
- Wrap: emit 256 symbols → dbg_sym_cnt returns to 0.
